// File: rtl/fft_apb_master.sv
// Single-outstanding APB requester: accepts one host command, runs the SETUP/ACCESS
// handshake with a bounded wait, and returns the result on a valid/ready response port.
module fft_apb_master #(
   parameter int APB_ADDR_WIDTH = 16,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                      clk_i,
   input  logic                      reset_n_i,
   input  logic                      cmd_valid_i,
   output logic                      cmd_ready_o,
   input  logic                      cmd_write_i,
   input  logic [APB_ADDR_WIDTH-1:0] cmd_addr_i,
   input  logic [31:0]               cmd_wdata_i,
   output logic                      rsp_valid_o,
   input  logic                      rsp_ready_i,
   output logic [31:0]               rsp_rdata_o,
   output logic                      rsp_err_o,
   output logic                      psel_o,
   output logic                      penable_o,
   output logic                      pwrite_o,
   output logic [APB_ADDR_WIDTH-1:0] paddr_o,
   output logic [31:0]               pwdata_o,
   input  logic [31:0]               prdata_i,
   input  logic                      pready_i,
   output logic [7:0]                timeout_count_o
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      RESP   = 2'd3
   } state_e;

   // Wait-counter value of the last ACCESS cycle before the transfer is abandoned.
   localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYCLES - 1);

   state_e                    state_q, state_d;
   logic                      psel_q, psel_d;
   logic                      penable_q, penable_d;
   logic                      pwrite_q, pwrite_d;
   logic [APB_ADDR_WIDTH-1:0] paddr_q, paddr_d;
   logic [31:0]               pwdata_q, pwdata_d;
   logic [31:0]               rsp_rdata_q, rsp_rdata_d;
   logic                      rsp_err_q, rsp_err_d;
   logic [7:0]                timeout_count_q, timeout_count_d;
   logic [15:0]               wait_cnt_q, wait_cnt_d;

   always_comb begin
      // NOTE: every _d starts from its _q so no path through the case leaves a
      // signal unassigned; that is what keeps this block free of inferred latches.
      state_d         = state_q;
      psel_d          = psel_q;
      penable_d       = penable_q;
      pwrite_d        = pwrite_q;
      paddr_d         = paddr_q;
      pwdata_d        = pwdata_q;
      rsp_rdata_d     = rsp_rdata_q;
      rsp_err_d       = rsp_err_q;
      timeout_count_d = timeout_count_q;
      wait_cnt_d      = wait_cnt_q;

      case (state_q)
         IDLE: begin
            if (cmd_valid_i) begin
               // Command fields land directly in the APB output registers; they only
               // change together with psel rising.
               pwrite_d   = cmd_write_i;
               paddr_d    = cmd_addr_i;
               pwdata_d   = cmd_wdata_i;
               psel_d     = 1'b1;
               penable_d  = 1'b0;
               wait_cnt_d = '0;
               state_d    = SETUP;
            end
         end
         SETUP: begin
            penable_d = 1'b1;
            state_d   = ACCESS;
         end
         ACCESS: begin
            wait_cnt_d = wait_cnt_q + 16'd1;
            if (pready_i) begin
               rsp_rdata_d = pwrite_q ? 32'd0 : prdata_i;
               rsp_err_d   = 1'b0;
               psel_d      = 1'b0;
               penable_d   = 1'b0;
               state_d     = RESP;
            end else if (wait_cnt_q == WAIT_LAST) begin
               rsp_rdata_d = 32'd0;
               rsp_err_d   = 1'b1;
               if (timeout_count_q != 8'hFF) timeout_count_d = timeout_count_q + 8'd1;
               psel_d      = 1'b0;
               penable_d   = 1'b0;
               state_d     = RESP;
            end
         end
         RESP: begin
            if (rsp_ready_i) state_d = IDLE;
         end
         default: begin
            psel_d    = 1'b0;
            penable_d = 1'b0;
            state_d   = IDLE;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples the
   // pre-edge values computed above, independent of statement order.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q         <= IDLE;
         psel_q          <= 1'b0;
         penable_q       <= 1'b0;
         pwrite_q        <= 1'b0;
         paddr_q         <= '0;
         pwdata_q        <= 32'd0;
         rsp_rdata_q     <= 32'd0;
         rsp_err_q       <= 1'b0;
         timeout_count_q <= 8'd0;
         wait_cnt_q      <= 16'd0;
      end else begin
         state_q         <= state_d;
         psel_q          <= psel_d;
         penable_q       <= penable_d;
         pwrite_q        <= pwrite_d;
         paddr_q         <= paddr_d;
         pwdata_q        <= pwdata_d;
         rsp_rdata_q     <= rsp_rdata_d;
         rsp_err_q       <= rsp_err_d;
         timeout_count_q <= timeout_count_d;
         wait_cnt_q      <= wait_cnt_d;
      end
   end

   assign cmd_ready_o     = (state_q == IDLE);
   assign rsp_valid_o     = (state_q == RESP);
   assign psel_o          = psel_q;
   assign penable_o       = penable_q;
   assign pwrite_o        = pwrite_q;
   assign paddr_o         = paddr_q;
   assign pwdata_o        = pwdata_q;
   assign rsp_rdata_o     = rsp_rdata_q;
   assign rsp_err_o       = rsp_err_q;
   assign timeout_count_o = timeout_count_q;

endmodule
